// File: rtl/banked_sram_ctrl.sv
// banked_sram_ctrl: banked static RAM behind a clocked req/ack access controller
// with WAIT programmable wait states per access.
// Ports: clock, reset (async, active high), req/rw/addr/data_in (request side),
// data_out (registered read data), ack, s_ (active-low bank selects), busy,
// perr (read parity error, only when BANKED_SRAM_PARITY_EN is defined).
// Optional feature macro: BANKED_SRAM_PARITY_EN adds a stored even-parity bit per word.
module banked_sram_ctrl #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int B    = 2,
    parameter int WAIT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                rw,
    input  logic [B+M-1:0]      addr,
    input  logic [N-1:0]        data_in,
    output logic [N-1:0]        data_out,
    output logic                ack,
    output logic [(1<<B)-1:0]   s_,
`ifdef BANKED_SRAM_PARITY_EN
    output logic                busy,
    output logic                perr
`else
    output logic                busy
`endif
);

    localparam int BANKS = 1 << B;
    localparam int DEPTH = BANKS << M;
`ifdef BANKED_SRAM_PARITY_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [B+M-1:0] addr_q, addr_d;
    logic           rw_q, rw_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic [N-1:0]   data_out_q, data_out_d;
`ifdef BANKED_SRAM_PARITY_EN
    logic           perr_q, perr_d;
`endif

    // Storage is flat; the bank is simply the upper address field.
    logic [W-1:0]   mem [DEPTH];
    logic [W-1:0]   rd_word;
    logic [W-1:0]   wr_word;
    logic           commit;

    assign commit  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign rd_word = mem[addr_q];
`ifdef BANKED_SRAM_PARITY_EN
    // Even parity: stored word including the parity bit XORs to zero.
    assign wr_word = {^wdata_q, wdata_q};
`else
    assign wr_word = wdata_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
`ifdef BANKED_SRAM_PARITY_EN
        perr_d     = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    wdata_d = data_in;
                    cnt_d   = 4'(WAIT);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (rw_q) begin
                        data_out_d = rd_word[N-1:0];
`ifdef BANKED_SRAM_PARITY_EN
                        perr_d     = ^rd_word;
`endif
                    end
                end
            end
            DONE: begin
                // A held req keeps us here; a new access needs req low first.
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            data_out_q <= '0;
`ifdef BANKED_SRAM_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
`ifdef BANKED_SRAM_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    // Contents survive reset; a write in flight is dropped because reset
    // forces the state out of ACCESS before its commit edge.
    always_ff @(posedge clock) begin
        if (commit && !rw_q) begin
            mem[addr_q] <= wr_word;
        end
    end

    always_comb begin
        s_ = '1;
        if (state_q == ACCESS) begin
            s_[addr_q[B+M-1:M]] = 1'b0;
        end
    end

    assign ack      = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign data_out = data_out_q;
`ifdef BANKED_SRAM_PARITY_EN
    assign perr     = perr_q;
`endif

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// tb_banked_sram_ctrl: directed checks for banked_sram_ctrl, two instances
// (WAIT=1 and WAIT=3) sharing one request stream.
module tb_banked_sram_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       rst2;
    logic       req;
    logic       block2;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data_in;
    logic [7:0] do1, do2;
    logic       ack1, ack2, busy1, busy2;
    logic [3:0] s1, s2;
`ifdef BANKED_SRAM_PARITY_EN
    logic       perr1, perr2;
`endif
    logic       req2;
    logic       reset2;

    int checks = 0;
    int errors = 0;

    assign req2   = req & ~block2;
    assign reset2 = reset | rst2;

    always #5 clock = ~clock;

    banked_sram_ctrl #(.N(8), .M(4), .B(2), .WAIT(1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(do1), .ack(ack1), .s_(s1),
`ifdef BANKED_SRAM_PARITY_EN
        .busy(busy1), .perr(perr1)
`else
        .busy(busy1)
`endif
    );

    banked_sram_ctrl #(.N(8), .M(4), .B(2), .WAIT(3)) dut2 (
        .clock(clock), .reset(reset2), .req(req2), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(do2), .ack(ack2), .s_(s2),
`ifdef BANKED_SRAM_PARITY_EN
        .busy(busy2), .perr(perr2)
`else
        .busy(busy2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full handshake on both instances; hold = extra cycles req stays high after ack.
    task automatic access(input logic r, input logic [5:0] a, input logic [7:0] d,
                          input logic [3:0] es, input logic [7:0] e1,
                          input logic [7:0] e2, input int hold);
        int n;
        int l1;
        int l2;
        @(negedge clock);
        req = 1'b1; rw = r; addr = a; data_in = d;
        @(posedge clock); #1;
        chk("s1_access", 32'(s1), 32'(es));
        chk("s2_access", 32'(s2), 32'(es));
        chk("busy1_access", 32'(busy1), 32'd1);
        n = 1; l1 = 0; l2 = 0;
        while ((l1 == 0 || l2 == 0) && n < 30) begin
            @(posedge clock); #1;
            n++;
            if (ack1 && l1 == 0) l1 = n;
            if (ack2 && l2 == 0) l2 = n;
        end
        chk("lat1", 32'(l1), 32'd3);
        chk("lat2", 32'(l2), 32'd5);
        chk("s1_done", 32'(s1), 32'hf);
        chk("do1", 32'(do1), 32'(e1));
        chk("do2", 32'(do2), 32'(e2));
        repeat (hold) begin
            @(posedge clock); #1;
            chk("ack1_hold", 32'(ack1), 32'd1);
            chk("ack2_hold", 32'(ack2), 32'd1);
            chk("s1_hold", 32'(s1), 32'hf);
            chk("s2_hold", 32'(s2), 32'hf);
        end
        @(negedge clock);
        req = 1'b0;
        @(posedge clock); #1;
        chk("ack1_drop", 32'(ack1), 32'd0);
        chk("ack2_drop", 32'(ack2), 32'd0);
        chk("busy1_idle", 32'(busy1), 32'd0);
        chk("busy2_idle", 32'(busy2), 32'd0);
    endtask

    typedef struct {
        logic       r;
        logic [5:0] a;
        logic [7:0] d;
        logic [3:0] es;
        logic [7:0] edo;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 6'h03, 8'hA5, 4'b1110, 8'h00};
        vecs[1] = '{1'b0, 6'h13, 8'h3C, 4'b1101, 8'h00};
        vecs[2] = '{1'b0, 6'h23, 8'hF0, 4'b1011, 8'h00};
        vecs[3] = '{1'b0, 6'h33, 8'h0F, 4'b0111, 8'h00};
        vecs[4] = '{1'b0, 6'h10, 8'h3C, 4'b1101, 8'h00};
        vecs[5] = '{1'b1, 6'h03, 8'h00, 4'b1110, 8'hA5};
        vecs[6] = '{1'b1, 6'h13, 8'h00, 4'b1101, 8'h3C};
        vecs[7] = '{1'b1, 6'h23, 8'h00, 4'b1011, 8'hF0};
        vecs[8] = '{1'b1, 6'h33, 8'h00, 4'b0111, 8'h0F};
        vecs[9] = '{1'b1, 6'h10, 8'h00, 4'b1101, 8'h3C};

        reset = 1'b1; rst2 = 1'b0; req = 1'b0; block2 = 1'b0;
        rw = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clock);
            chk("rst1", {17'd0, ack1, busy1, s1, do1}, {17'd0, 1'b0, 1'b0, 4'hf, 8'h00});
            chk("rst2", {17'd0, ack2, busy2, s2, do2}, {17'd0, 1'b0, 1'b0, 4'hf, 8'h00});
        end
`ifdef BANKED_SRAM_PARITY_EN
        chk("perr_rst", 32'({perr1, perr2}), 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].es,
                   vecs[i].edo, vecs[i].edo, 0);
        end

        // Held req after ack: no second access, single write.
        access(1'b0, 6'h01, 8'h5A, 4'b1110, 8'h3C, 8'h3C, 6);
        access(1'b1, 6'h01, 8'h00, 4'b1110, 8'h5A, 8'h5A, 0);

        // Operand freeze.
        access(1'b0, 6'h25, 8'h42, 4'b1011, 8'h5A, 8'h5A, 0);
        @(negedge clock);
        req = 1'b1; rw = 1'b0; addr = 6'h05; data_in = 8'h11;
        @(posedge clock); #1;
        addr = 6'h25; data_in = 8'h99;
        chk("s1_freeze", 32'(s1), 32'b1110);
        repeat (4) begin
            @(posedge clock); #1;
            chk("s1_freeze_held", 32'(s1 & s2), 32'(ack1 ? (ack2 ? 4'hf : 4'b1110) : 4'b1110));
        end
        chk("ack_freeze", 32'({ack1, ack2}), 32'b11);
        @(negedge clock);
        req = 1'b0;
        @(posedge clock); #1;
        access(1'b1, 6'h05, 8'h00, 4'b1110, 8'h11, 8'h11, 0);
        access(1'b1, 6'h25, 8'h00, 4'b1011, 8'h42, 8'h42, 0);

        // Reset mid-write on the WAIT=3 instance only.
        @(negedge clock);
        req = 1'b1; rw = 1'b0; addr = 6'h10; data_in = 8'h77;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("busy2_pre_rst", 32'(busy2), 32'd1);
        rst2 = 1'b1; block2 = 1'b1;
        #1;
        chk("rst_mid", {18'd0, ack2, busy2, s2, do2}, {18'd0, 1'b0, 1'b0, 4'hf, 8'h00});
        @(negedge clock);
        rst2 = 1'b0;
        @(posedge clock); #1;
        chk("ack1_mid", 32'(ack1), 32'd1);
        chk("busy2_after", 32'(busy2), 32'd0);
        @(negedge clock);
        req = 1'b0;
        @(posedge clock); #1;
        block2 = 1'b0;
        access(1'b1, 6'h10, 8'h00, 4'b1101, 8'h77, 8'h3C, 0);

`ifdef BANKED_SRAM_PARITY_EN
        access(1'b0, 6'h07, 8'h01, 4'b1110, 8'h77, 8'h3C, 0);
        @(negedge clock);
        dut1.mem[7][0] = ~dut1.mem[7][0];
        dut2.mem[7][0] = ~dut2.mem[7][0];
        access(1'b1, 6'h07, 8'h00, 4'b1110, 8'h00, 8'h00, 0);
        chk("perr1_bad", 32'(perr1), 32'd1);
        chk("perr2_bad", 32'(perr2), 32'd1);
        access(1'b1, 6'h03, 8'h00, 4'b1110, 8'hA5, 8'hA5, 0);
        chk("perr1_ok", 32'(perr1), 32'd0);
        chk("perr2_ok", 32'(perr2), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
